// File: rtl/router_pkg.sv
// Shared types and widths for the router test/ingress path.
// Holds the scheduler state encoding and the transmitter field widths.
package router_pkg;

    localparam int SRCID_W       = 8;
    localparam int DSTID_W       = 8;
    localparam int SIZE_W        = 3;
    localparam int TX_GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_END,
        S_GAP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr_i.
// Ports: req_i request vector, ptr_i start index, gnt_o one-hot winner, valid_o any request.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;

    // Rotate so ptr_i lands at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        req_rot = N'({req_i, req_i} >> ptr_i);
        gnt_rot = '0;
        for (int j = 0; j < N; j++) begin
            if (req_rot[j] && gnt_rot == '0) begin
                gnt_rot[j] = 1'b1;
            end
        end
        gnt_o   = N'(({gnt_rot, gnt_rot} << ptr_i) >> N);
        valid_o = |req_i;
    end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Round-robin scheduler sharing one packet transmitter among NUM_REQ sources.
// Ports: req/req_* requests in, grant/reject/done/timeout_err pulses out, tx_* to transmitter.
module tx_packet_scheduler
    import router_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [SRCID_W*NUM_REQ-1:0] req_srcid,
    input  logic [DSTID_W*NUM_REQ-1:0] req_dstid,
    input  logic [SIZE_W*NUM_REQ-1:0]  req_size,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         reject,
    output logic [NUM_REQ-1:0]         done,
    output logic                       timeout_err,
    output logic [SRCID_W-1:0]         tx_srcid,
    output logic [DSTID_W-1:0]         tx_dstid,
    output logic [SIZE_W-1:0]          tx_size,
    output logic                       tx_start,
    input  logic                       tx_packet_starting,
    input  logic                       tx_packet_ending,
    output logic                       busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int WD = $clog2(TIMEOUT + 1);

    sched_state_t       state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SRCID_W-1:0] src_q, src_d;
    logic [DSTID_W-1:0] dst_q, dst_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] reject_q, reject_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               tmo_q, tmo_d;
    logic               start_q, start_d;
    logic [WD-1:0]      wdog_q, wdog_d;

    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] win;
    logic               win_vld;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      next_ptr;
    logic [SRCID_W-1:0] win_src;
    logic [DSTID_W-1:0] win_dst;
    logic [SIZE_W-1:0]  win_size;
    logic [WD-1:0]      wdog_inc;

    // A requester just granted/rejected may still hold req for one cycle.
    assign req_eff = req & ~mask_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (req_eff),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (win),
        .valid_o (win_vld)
    );

    always_comb begin
        win_idx  = '0;
        win_src  = '0;
        win_dst  = '0;
        win_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                win_src  = req_srcid[i*SRCID_W +: SRCID_W];
                win_dst  = req_dstid[i*DSTID_W +: DSTID_W];
                win_size = req_size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    assign next_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
    assign wdog_inc = wdog_q + WD'(1);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        dst_d    = dst_q;
        size_d   = size_q;
        grant_d  = '0;
        reject_d = '0;
        done_d   = '0;
        owner_d  = owner_q;
        mask_d   = '0;
        tmo_d    = 1'b0;
        start_d  = start_q;
        wdog_d   = wdog_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    rr_ptr_d = next_ptr;
                    mask_d   = win;
                    if (win_size != '0) begin
                        src_d   = win_src;
                        dst_d   = win_dst;
                        size_d  = win_size;
                        grant_d = win;
                        owner_d = win;
                        start_d = 1'b1;
                        state_d = S_LAUNCH;
                    end else begin
                        reject_d = win;
                    end
                end
            end
            S_LAUNCH: begin
                if (tx_packet_starting) begin
                    start_d = 1'b0;
                    wdog_d  = '0;
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                // Completion takes priority over a coincident terminal count.
                if (tx_packet_ending) begin
                    done_d  = owner_q;
                    state_d = S_GAP;
                end else if (wdog_inc == WD'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = S_GAP;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            grant_q  <= '0;
            reject_q <= '0;
            done_q   <= '0;
            owner_q  <= '0;
            mask_q   <= '0;
            tmo_q    <= 1'b0;
            start_q  <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            grant_q  <= grant_d;
            reject_q <= reject_d;
            done_q   <= done_d;
            owner_q  <= owner_d;
            mask_q   <= mask_d;
            tmo_q    <= tmo_d;
            start_q  <= start_d;
            wdog_q   <= wdog_d;
        end
    end

    assign grant       = grant_q;
    assign reject      = reject_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;
    assign tx_srcid    = src_q;
    assign tx_dstid    = dst_q;
    assign tx_size     = size_q;
    assign tx_start    = start_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Testbench for tx_packet_scheduler: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_tx_packet_scheduler;

    localparam int N   = 3;
    localparam int TMO = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_srcid;
    logic [8*N-1:0] req_dstid;
    logic [3*N-1:0] req_size;
    logic [N-1:0]   grant;
    logic [N-1:0]   reject;
    logic [N-1:0]   done;
    logic           timeout_err;
    logic [7:0]     tx_srcid;
    logic [7:0]     tx_dstid;
    logic [2:0]     tx_size;
    logic           tx_start;
    logic           tx_packet_starting;
    logic           tx_packet_ending;
    logic           busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    tx_packet_scheduler #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_srcid          (req_srcid),
        .req_dstid          (req_dstid),
        .req_size           (req_size),
        .grant              (grant),
        .reject             (reject),
        .done               (done),
        .timeout_err        (timeout_err),
        .tx_srcid           (tx_srcid),
        .tx_dstid           (tx_dstid),
        .tx_size            (tx_size),
        .tx_start           (tx_start),
        .tx_packet_starting (tx_packet_starting),
        .tx_packet_ending   (tx_packet_ending),
        .busy               (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic zero_inputs();
        req                = '0;
        req_srcid          = '0;
        req_dstid          = '0;
        req_size           = '0;
        tx_packet_starting = 1'b0;
        tx_packet_ending   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        zero_inputs();
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic set_req(input int i, input logic [7:0] s,
                           input logic [7:0] d, input logic [2:0] z);
        req[i]              = 1'b1;
        req_srcid[i*8 +: 8] = s;
        req_dstid[i*8 +: 8] = d;
        req_size[i*3 +: 3]  = z;
    endtask

    task automatic enter_wait();
        tx_packet_starting = 1'b1;
        step();
        tx_packet_starting = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        zero_inputs();
        step();
        n_total++;
        if ({grant, reject, done, timeout_err, tx_srcid, tx_dstid,
             tx_size, tx_start, busy} !== '0)
            $display("FAIL reset_outputs: got %b/%b/%b/%b %h %h %h %b %b exp all 0",
                     grant, reject, done, timeout_err, tx_srcid, tx_dstid,
                     tx_size, tx_start, busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        step();
        n_total++;
        if ({grant, reject, tx_start, busy} !== '0)
            $display("FAIL reset_idle: got grant %b reject %b start %b busy %b exp 0",
                     grant, reject, tx_start, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 8'h11, 8'h22, 3'd3);
        step();
        n_total++;
        if (grant !== 3'b010 || tx_start !== 1'b1)
            $display("FAIL single_grant: got grant %b start %b exp 010 1", grant, tx_start);
        else n_pass++;
        n_total++;
        if ({tx_srcid, tx_dstid, tx_size} !== {8'h11, 8'h22, 3'd3})
            $display("FAIL single_fields: got %h %h %0d exp 11 22 3",
                     tx_srcid, tx_dstid, tx_size);
        else n_pass++;
        req = '0;
        step();
        step();
        n_total++;
        if (tx_start !== 1'b1 || grant !== 3'b000)
            $display("FAIL single_hold: got start %b grant %b exp 1 000", tx_start, grant);
        else n_pass++;
        enter_wait();
        n_total++;
        if (tx_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_start_drop: got start %b busy %b exp 0 1", tx_start, busy);
        else n_pass++;
        step();
        step();
        tx_packet_ending = 1'b1;
        step();
        tx_packet_ending = 1'b0;
        n_total++;
        if (done !== 3'b010 || timeout_err !== 1'b0)
            $display("FAIL single_done: got done %b tmo %b exp 010 0", done, timeout_err);
        else n_pass++;
        step();
        n_total++;
        if (done !== 3'b000 || busy !== 1'b0 || tx_srcid !== 8'h11)
            $display("FAIL single_after: got done %b busy %b src %h exp 000 0 11",
                     done, busy, tx_srcid);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int done_cyc;
        logic [N-1:0] exp_oh;
        done_cyc = 0;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h40 + i), 8'(8'h80 + i), 3'd2);
        for (int k = 0; k < 4; k++) begin
            exp_oh = N'(1 << (k % N));
            for (int w = 0; w < 8 && grant == '0; w++) step();
            n_total++;
            if (grant !== exp_oh || tx_srcid !== 8'(8'h40 + k % N))
                $display("FAIL rot_grant%0d: got %b src %h exp %b src %h",
                         k, grant, tx_srcid, exp_oh, 8'(8'h40 + k % N));
            else n_pass++;
            if (k > 0) begin
                n_total++;
                if (cyc - done_cyc !== 2)
                    $display("FAIL rot_gap%0d: got %0d cycles exp 2", k, cyc - done_cyc);
                else n_pass++;
            end
            enter_wait();
            step();
            tx_packet_ending = 1'b1;
            step();
            tx_packet_ending = 1'b0;
            done_cyc = cyc;
            n_total++;
            if (done !== exp_oh)
                $display("FAIL rot_done%0d: got %b exp %b", k, done, exp_oh);
            else n_pass++;
        end
        req = '0;
    endtask

    task automatic test_reject();
        do_reset();
        set_req(0, 8'h01, 8'h02, 3'd0);
        set_req(2, 8'h33, 8'h44, 3'd4);
        step();
        n_total++;
        if (reject !== 3'b001 || grant !== 3'b000 || tx_start !== 1'b0)
            $display("FAIL rej_cycle1: got rej %b grant %b start %b exp 001 000 0",
                     reject, grant, tx_start);
        else n_pass++;
        step();
        req = '0;
        n_total++;
        if (grant !== 3'b100 || reject !== 3'b000 || tx_size !== 3'd4 || tx_srcid !== 8'h33)
            $display("FAIL rej_cycle2: got grant %b rej %b size %0d src %h exp 100 000 4 33",
                     grant, reject, tx_size, tx_srcid);
        else n_pass++;
        do_reset();
        set_req(0, 8'h05, 8'h06, 3'd0);
        step();
        step();
        n_total++;
        if (reject !== 3'b000)
            $display("FAIL rej_mask: got rej %b exp 000", reject);
        else n_pass++;
        step();
        req = '0;
        n_total++;
        if (reject !== 3'b001 || busy !== 1'b0)
            $display("FAIL rej_again: got rej %b busy %b exp 001 0", reject, busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit bad;
        bad = 1'b0;
        do_reset();
        set_req(0, 8'h55, 8'h66, 3'd5);
        step();
        req = '0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (tx_start !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        n_total++;
        if (bad)
            $display("FAIL stall_hold: got start %b tmo %b exp start held 1 no tmo",
                     tx_start, timeout_err);
        else n_pass++;
        enter_wait();
        n_total++;
        if (tx_start !== 1'b0)
            $display("FAIL stall_release: got start %b exp 0", tx_start);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        bit saw_done;
        n = -1;
        saw_done = 1'b0;
        do_reset();
        set_req(2, 8'h77, 8'h88, 3'd1);
        step();
        req = '0;
        enter_wait();
        for (int c = 1; c <= TMO + 10 && n < 0; c++) begin
            step();
            if (done !== '0) saw_done = 1'b1;
            if (timeout_err === 1'b1) n = c;
        end
        n_total++;
        if (n !== TMO || saw_done)
            $display("FAIL tmo_cycle: got %0d done_seen %b exp %0d 0", n, saw_done, TMO);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL tmo_idle: got busy %b tmo %b exp 0 0", busy, timeout_err);
        else n_pass++;
        do_reset();
        set_req(1, 8'h99, 8'hAA, 3'd7);
        step();
        req = '0;
        enter_wait();
        repeat (TMO - 1) step();
        tx_packet_ending = 1'b1;
        step();
        tx_packet_ending = 1'b0;
        n_total++;
        if (done !== 3'b010 || timeout_err !== 1'b0)
            $display("FAIL tmo_tie: got done %b tmo %b exp 010 0", done, timeout_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 8'hC1, 8'hC2, 3'd6);
        step();
        set_req(2, 8'hD1, 8'hD2, 3'd6);
        step();
        step();
        enter_wait();
        step();
        rst = 1'b0;
        #1;
        n_total++;
        if ({grant, reject, done, timeout_err, tx_srcid, tx_dstid,
             tx_size, tx_start, busy} !== '0)
            $display("FAIL rst_mid: got start %b busy %b src %h exp all 0",
                     tx_start, busy, tx_srcid);
        else n_pass++;
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 8'(8'hE0 + i), 8'hE8, 3'd1);
        step();
        n_total++;
        if (grant !== 3'b001 || tx_srcid !== 8'hE0)
            $display("FAIL rst_first_grant: got %b src %h exp 001 e0", grant, tx_srcid);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] oh;
        logic [7:0]   s[N];
        logic [7:0]   d[N];
        logic [2:0]   z[N];
        int ptr, cool, cand, ed;
        bit early;
        pend = '0;
        ptr  = 0;
        cool = -1;
        for (int i = 0; i < N; i++) begin
            s[i] = '0;
            d[i] = '0;
            z[i] = '0;
        end
        do_reset();
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && i != cool && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    s[i] = 8'($urandom);
                    d[i] = 8'($urandom);
                    z[i] = ($urandom_range(5, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
                end
            end
            cool = -1;
            zero_inputs();
            for (int i = 0; i < N; i++)
                if (pend[i]) set_req(i, s[i], d[i], z[i]);
            cand = -1;
            for (int k = 0; k < N; k++)
                if (cand < 0 && pend[(ptr + k) % N]) cand = (ptr + k) % N;
            step();
            if (cand < 0) begin
                n_total++;
                if (grant !== '0 || reject !== '0 || busy !== 1'b0)
                    $display("FAIL rnd_idle%0d: got grant %b rej %b busy %b exp 0",
                             r, grant, reject, busy);
                else n_pass++;
                continue;
            end
            oh = N'(1 << cand);
            ptr = (cand + 1) % N;
            pend[cand] = 1'b0;
            req[cand] = 1'b0;
            if (z[cand] == 3'd0) begin
                cool = cand;
                n_total++;
                if (reject !== oh || grant !== '0)
                    $display("FAIL rnd_reject%0d: got rej %b grant %b exp %b 000",
                             r, reject, grant, oh);
                else n_pass++;
                continue;
            end
            n_total++;
            if (grant !== oh || tx_start !== 1'b1 ||
                {tx_srcid, tx_dstid, tx_size} !== {s[cand], d[cand], z[cand]})
                $display("FAIL rnd_grant%0d: got %b %h %h %0d exp %b %h %h %0d", r,
                         grant, tx_srcid, tx_dstid, tx_size, oh, s[cand], d[cand], z[cand]);
            else n_pass++;
            repeat ($urandom_range(4, 0)) step();
            enter_wait();
            ed = ($urandom_range(3, 0) == 0) ? TMO + 3 : $urandom_range(TMO - 1, 0);
            early = 1'b0;
            for (int c = 1; c <= TMO; c++) begin
                if (c == ed + 1) tx_packet_ending = 1'b1;
                step();
                tx_packet_ending = 1'b0;
                if (c == ed + 1) begin
                    n_total++;
                    if (done !== oh || timeout_err !== 1'b0 || early)
                        $display("FAIL rnd_done%0d: got %b tmo %b early %b exp %b 0 0",
                                 r, done, timeout_err, early, oh);
                    else n_pass++;
                    break;
                end else if (c == TMO) begin
                    n_total++;
                    if (timeout_err !== 1'b1 || done !== '0 || early)
                        $display("FAIL rnd_tmo%0d: got tmo %b done %b early %b exp 1 0 0",
                                 r, timeout_err, done, early);
                    else n_pass++;
                end else if (done !== '0 || timeout_err !== 1'b0) begin
                    early = 1'b1;
                end
            end
            step();
            n_total++;
            if (busy !== 1'b0 || done !== '0 || timeout_err !== 1'b0)
                $display("FAIL rnd_gap%0d: got busy %b done %b tmo %b exp 0",
                         r, busy, done, timeout_err);
            else n_pass++;
        end
        zero_inputs();
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_single();
        test_rotation();
        test_reject();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
